// File: rtl/mat_vec_res_serializer.sv
// ============================================================================
// Module      : mat_vec_res_serializer
// Description : Reads result words from the matrix-vector multiplier, adds an
//               optional GF(2^8) addend word (XOR) and streams the sum out as
//               bytes on a valid/ready interface, MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_vec_res_serializer #(
    parameter int N_GF      = 8,
    parameter int PROC_SIZE = N_GF * 8,
    parameter int OUT_BYTES = 126,
    parameter int N_WORDS   = (OUT_BYTES + N_GF - 1) / N_GF,
    parameter int AW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_add_en,
    output logic                 o_res_en,
    output logic [AW-1:0]        o_res_addr,
    input  logic [PROC_SIZE-1:0] i_res,
    output logic [AW-1:0]        o_add_addr,
    input  logic [PROC_SIZE-1:0] i_add,
    output logic [7:0]           o_byte,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    // Byte counter must be able to hold N_GF itself after the final increment.
    localparam int            c_BW       = $clog2(N_GF + 1);
    localparam logic [c_BW-1:0] c_FULL_LIM = c_BW'(N_GF);
    localparam logic [c_BW-1:0] c_LAST_LIM = c_BW'(OUT_BYTES - (N_WORDS - 1) * N_GF);
    localparam logic [AW-1:0]   c_LAST_W   = AW'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [AW-1:0]          r_w;
    logic [c_BW-1:0]        r_b;
    logic [c_BW-1:0]        r_lim;
    logic [PROC_SIZE-1:0]   r_sr;
    logic [7:0]             r_byte;
    logic                   r_add_en;

    logic                   w_hs;
    logic                   w_last_byte;
    logic                   w_last_word;
    logic [PROC_SIZE-1:0]   w_word;

    assign w_hs        = (r_state == S_SHIFT) && i_ready;
    assign w_last_byte = (r_b == (r_lim - c_BW'(1)));
    assign w_last_word = (r_w == c_LAST_W);
    assign w_word      = i_res ^ (r_add_en ? i_add : '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_hs && w_last_byte) begin
                    w_next = w_last_word ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_w      <= '0;
            r_b      <= '0;
            r_lim    <= '0;
            r_sr     <= '0;
            r_byte   <= '0;
            r_add_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_add_en <= i_add_en;
                        r_w      <= '0;
                    end
                end
                S_LOAD: begin
                    r_sr   <= w_word;
                    r_byte <= w_word[PROC_SIZE-1 -: 8];
                    r_b    <= '0;
                    r_lim  <= w_last_word ? c_LAST_LIM : c_FULL_LIM;
                end
                S_SHIFT: begin
                    if (w_hs) begin
                        r_sr <= r_sr << 8;
                        r_b  <= r_b + c_BW'(1);
                        // Output byte is pre-loaded with the next one so it stays registered.
                        r_byte <= w_last_byte ? 8'h00 : r_sr[PROC_SIZE-9 -: 8];
                        if (w_last_byte && !w_last_word) begin
                            r_w <= r_w + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_res_en   = (r_state == S_FETCH);
    assign o_res_addr = r_w;
    assign o_add_addr = r_w;
    assign o_byte     = r_byte;
    assign o_valid    = (r_state == S_SHIFT);
    assign o_busy     = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_SHIFT);
    assign o_done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mat_vec_res_serializer.sv
// ============================================================================
// Module      : tb_mat_vec_res_serializer
// Description : Directed self-checking bench for mat_vec_res_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_vec_res_serializer;

    localparam int c_PS = 64;
    localparam int c_AW = 4;

    logic clk;
    logic i_rst;
    logic start1, start2;
    logic add_en;
    logic ready;

    logic [c_PS-1:0] res_mem [16];
    logic [c_PS-1:0] add_mem [16];
    logic [c_PS-1:0] res_q1, add_q1, res_q2, add_q2;

    logic            res_en1, res_en2, valid1, valid2, busy1, busy2, done1, done2;
    logic [c_AW-1:0] res_addr1, res_addr2, add_addr1, add_addr2;
    logic [7:0]      byte1, byte2;

    int  n_vec = 0;
    int  n_err = 0;
    bit  sel   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mat_vec_res_serializer dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_start(start1), .i_add_en(add_en),
        .o_res_en(res_en1), .o_res_addr(res_addr1), .i_res(res_q1),
        .o_add_addr(add_addr1), .i_add(add_q1),
        .o_byte(byte1), .o_valid(valid1), .i_ready(ready),
        .o_busy(busy1), .o_done(done1)
    );

    mat_vec_res_serializer #(.OUT_BYTES(128)) dut2 (
        .i_clk(clk), .i_rst(i_rst), .i_start(start2), .i_add_en(add_en),
        .o_res_en(res_en2), .o_res_addr(res_addr2), .i_res(res_q2),
        .o_add_addr(add_addr2), .i_add(add_q2),
        .o_byte(byte2), .o_valid(valid2), .i_ready(ready),
        .o_busy(busy2), .o_done(done2)
    );

    // Synchronous-read RAM models, one cycle latency
    always @(posedge clk) begin
        if (res_en1) begin
            res_q1 <= res_mem[res_addr1];
            add_q1 <= add_mem[add_addr1];
        end
        if (res_en2) begin
            res_q2 <= res_mem[res_addr2];
            add_q2 <= add_mem[add_addr2];
        end
    end

    wire            s_valid    = sel ? valid2    : valid1;
    wire [7:0]      s_byte     = sel ? byte2     : byte1;
    wire            s_busy     = sel ? busy2     : busy1;
    wire            s_done     = sel ? done2     : done1;
    wire            s_res_en   = sel ? res_en2   : res_en1;
    wire [c_AW-1:0] s_res_addr = sel ? res_addr2 : res_addr1;
    wire [c_AW-1:0] s_add_addr = sel ? add_addr2 : add_addr1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    // One run; cycle 0 is the cycle in which i_start is sampled.
    task automatic run(input bit s, input bit add, input bit toggle, input bit repulse,
                       input int exp_bytes, input int exp_done, input int abort_at);
        int       cyc;
        int       nbytes;
        int       done_cyc;
        bit       stall_pending;
        bit       rdy;
        logic [7:0] stall_byte;
        logic [7:0] exp_b;
        sel      = s;
        add_en   = add;
        ready    = 1'b1;
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        add_en        = 1'b0;
        cyc           = 1;
        nbytes        = 0;
        done_cyc      = -1;
        stall_pending = 1'b0;
        stall_byte    = 8'h00;
        while (cyc < 600) begin
            rdy   = toggle ? (cyc % 2 == 0) : 1'b1;
            ready = rdy;
            set_start((repulse && cyc == 50) ? 1'b1 : 1'b0);
            if (cyc == abort_at) begin
                i_rst = 1'b0;
                #1;
                check("abort_valid", int'(s_valid), 0);
                check("abort_byte", int'(s_byte), 0);
                check("abort_busy", int'(s_busy), 0);
                check("abort_res_en", int'(s_res_en), 0);
                check("abort_addr", int'(s_res_addr), 0);
                check("abort_done", int'(s_done), 0);
                #1;
                i_rst = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (s_done || s_valid) begin
                        check("abort_quiet", int'({s_done, s_valid}), 0);
                    end
                end
                check("abort_idle_busy", int'(s_busy), 0);
                return;
            end
            if (stall_pending) begin
                check("stall_hold_byte", int'(s_byte), int'(stall_byte));
                check("stall_hold_valid", int'(s_valid), 1);
            end
            if (!s_valid && s_byte != 8'h00) begin
                check("byte_zero_when_idle", int'(s_byte), 0);
            end
            if (s_res_en && s_res_addr != s_add_addr) begin
                check("add_addr_eq_res_addr", int'(s_add_addr), int'(s_res_addr));
            end
            if (s_valid && rdy) begin
                exp_b = 8'(nbytes / 8) ^ (add ? 8'hFF : 8'h00);
                check($sformatf("byte[%0d]", nbytes), int'(s_byte), int'(exp_b));
                nbytes++;
            end
            stall_pending = s_valid && !rdy;
            stall_byte    = s_byte;
            if (s_done) begin
                done_cyc = cyc;
                check("busy_low_at_done", int'(s_busy), 0);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ready = 1'b1;
        set_start(1'b0);
        check("byte_count", nbytes, exp_bytes);
        check("done_cycle", done_cyc, exp_done);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(s_done), 0);
    endtask

    initial begin
        i_rst  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        add_en = 1'b0;
        ready  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            res_mem[k] = {8{8'(k)}};
            add_mem[k] = {c_PS{1'b1}};
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid1), 0);
        check("rst_byte", int'(byte1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_res_en", int'(res_en1), 0);
        check("rst_res_addr", int'(res_addr1), 0);
        check("rst_add_addr", int'(add_addr1), 0);
        i_rst = 1'b1;
        @(posedge clk);
        #1;

        run(1'b0, 1'b0, 1'b0, 1'b0, 126, 159, -1);   // plain stream
        run(1'b0, 1'b1, 1'b0, 1'b0, 126, 159, -1);   // with 0xFF addend
        run(1'b0, 1'b0, 1'b1, 1'b0, 126, 285, -1);   // alternating ready
        run(1'b0, 1'b0, 1'b0, 1'b1, 126, 159, -1);   // stray start mid-run
        run(1'b0, 1'b0, 1'b0, 1'b0, 126, 159, 40);   // reset abort
        run(1'b0, 1'b0, 1'b0, 1'b0, 126, 159, -1);   // clean rerun after abort
        run(1'b1, 1'b0, 1'b0, 1'b0, 128, 161, -1);   // OUT_BYTES=128

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
